// File: rtl/hps_loanio_pkg.sv
// Shared definitions for the HPS loan-IO bridge: command field layout, opcodes and FSM states.
package hps_loanio_pkg;

    localparam int BANK_W  = 16;
    localparam int TOG_BIT = 31;
    localparam int OP_LSB  = 28;
    localparam int OP_W    = 3;
    localparam int IDX_LSB = 21;
    localparam int IDX_W   = 7;
    localparam int DATA_W  = 16;
    localparam int ACK_BIT = 31;
    localparam int ERR_BIT = 30;

    typedef enum logic [OP_W-1:0] {
        OP_NOP           = 3'd0,
        OP_WR_OUT_BIT    = 3'd1,
        OP_WR_OE_BIT     = 3'd2,
        OP_RD_BIT        = 3'd3,
        OP_WR_OUT_BANK   = 3'd4,
        OP_WR_OE_BANK    = 3'd5,
        OP_RD_BANK       = 3'd6,
        OP_CLR_EDGE_BANK = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/loanio_debounce.sv
// One loan-IO input debouncer: the output follows the input only after three
// consecutive differing samples taken on the shared sample tick.
module loanio_debounce
    import hps_loanio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic dout
);

    logic [1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= din;
            run_cnt <= '0;
        end else if (tick) begin
            if (din == dout) begin
                run_cnt <= '0;
            end else if (run_cnt == 2'd2) begin
                dout    <= din;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/hps_loanio_bridge.sv
// HPS GP-mailbox to loan-IO bridge: toggle-handshaked commands drive per-channel out/OE
// registers and read synced inputs and sticky edge flags. Optional LOANIO_DEBOUNCE_EN.
//
// state   | meaning
// IDLE    | waiting for synced tog to differ from prev_tog
// EXEC    | decode latched command, apply writes, register response
// RESP    | response visible on gp_in, new toggles ignored
module hps_loanio_bridge
    import hps_loanio_pkg::*;
#(
    parameter int NUM_CH      = 67,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_DIV     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       gp_out,
    output logic [31:0]       gp_in,
    input  logic [NUM_CH-1:0] loanio_in,
    output logic [NUM_CH-1:0] loanio_out,
    output logic [NUM_CH-1:0] loanio_oe,
    output logic              edge_irq
);

    localparam int CMD_W = 1 + OP_W + IDX_W + DATA_W;

    if (NUM_CH < 1 || NUM_CH > 128 || SYNC_STAGES < 2 || DEB_DIV < 1) begin : g_bad_param
        $error("hps_loanio_bridge: parameter out of range");
    end

    // Synchronisers are deliberately not reset so reset can sample a settled tog.
    logic [CMD_W-1:0]  cmd_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] in_sync  [SYNC_STAGES];

    always_ff @(posedge clk) begin
        cmd_sync[0] <= {gp_out[TOG_BIT], gp_out[OP_LSB +: OP_W],
                        gp_out[IDX_LSB +: IDX_W], gp_out[DATA_W-1:0]};
        in_sync[0]  <= loanio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            cmd_sync[i] <= cmd_sync[i-1];
            in_sync[i]  <= in_sync[i-1];
        end
    end

    logic              tog_s;
    logic [OP_W-1:0]   op_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] data_s;
    assign {tog_s, op_s, idx_s, data_s} = cmd_sync[SYNC_STAGES-1];

    logic [NUM_CH-1:0] in_val;

`ifdef LOANIO_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_DIV + 1);
    logic [DCW-1:0] deb_cnt;
    logic           deb_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt  <= DCW'(DEB_DIV - 1);
            deb_tick <= 1'b0;
        end else if (deb_cnt == '0) begin
            deb_cnt  <= DCW'(DEB_DIV - 1);
            deb_tick <= 1'b1;
        end else begin
            deb_cnt  <= deb_cnt - DCW'(1);
            deb_tick <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        loanio_debounce u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (deb_tick),
            .din   (in_sync[SYNC_STAGES-1][g]),
            .dout  (in_val[g])
        );
    end
`else
    assign in_val = in_sync[SYNC_STAGES-1];
`endif

    state_e            state;
    logic              prev_tog;
    logic              cmd_tog;
    op_e               cmd_op;
    logic [IDX_W-1:0]  cmd_idx;
    logic [DATA_W-1:0] cmd_data;
    logic [NUM_CH-1:0] out_q, oe_q, edge_q, in_prev;
    logic              ack_q, err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [NUM_CH-1:0] out_w, oe_w, clr_w;
    logic              x_err;
    logic [DATA_W-1:0] x_rdata;
    logic              bit_ok, bank_ok;

    always_comb begin
        bit_ok  = int'(cmd_idx) < NUM_CH;
        bank_ok = int'(cmd_idx) * BANK_W < NUM_CH;
        out_w   = out_q;
        oe_w    = oe_q;
        clr_w   = '0;
        x_err   = 1'b0;
        x_rdata = '0;
        case (cmd_op)
            OP_WR_OUT_BIT, OP_WR_OE_BIT, OP_RD_BIT: x_err = !bit_ok;
            OP_WR_OUT_BANK, OP_WR_OE_BANK, OP_RD_BANK, OP_CLR_EDGE_BANK: x_err = !bank_ok;
            default: x_err = 1'b0;
        endcase
        // Out-of-range indices match no channel below, so errors leave state untouched.
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == int'(cmd_idx)) begin
                case (cmd_op)
                    OP_WR_OUT_BIT: out_w[c] = cmd_data[0];
                    OP_WR_OE_BIT:  oe_w[c]  = cmd_data[0];
                    OP_RD_BIT:     x_rdata  = {12'b0, edge_q[c], oe_q[c], out_q[c], in_val[c]};
                    default: ;
                endcase
            end
            if (c / BANK_W == int'(cmd_idx)) begin
                case (cmd_op)
                    OP_WR_OUT_BANK:   out_w[c] = cmd_data[c % BANK_W];
                    OP_WR_OE_BANK:    oe_w[c]  = cmd_data[c % BANK_W];
                    OP_RD_BANK:       x_rdata[c % BANK_W] = in_val[c];
                    OP_CLR_EDGE_BANK: begin
                        x_rdata[c % BANK_W] = edge_q[c];
                        clr_w[c]            = cmd_data[c % BANK_W] && state == ST_EXEC;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            prev_tog <= tog_s;
            ack_q    <= tog_s;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cmd_tog  <= tog_s;
            cmd_op   <= OP_NOP;
            cmd_idx  <= '0;
            cmd_data <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            edge_q   <= '0;
            in_prev  <= in_val;
            edge_irq <= 1'b0;
        end else begin
            in_prev  <= in_val;
            // Set term is ORed last so a same-cycle input edge beats a clear.
            edge_q   <= (edge_q & ~clr_w) | (in_val ^ in_prev);
            edge_irq <= |edge_q;
            case (state)
                ST_IDLE: begin
                    if (tog_s != prev_tog) begin
                        cmd_tog  <= tog_s;
                        cmd_op   <= op_e'(op_s);
                        cmd_idx  <= idx_s;
                        cmd_data <= data_s;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!x_err) begin
                        out_q <= out_w;
                        oe_q  <= oe_w;
                    end
                    err_q    <= x_err;
                    rdata_q  <= x_err ? '0 : x_rdata;
                    ack_q    <= cmd_tog;
                    prev_tog <= cmd_tog;
                    state    <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gp_in      = {ack_q, err_q, 14'b0, rdata_q};
    assign loanio_out = out_q;
    assign loanio_oe  = oe_q;

endmodule

// File: tb/tb_hps_loanio_bridge.sv
// Directed bench for hps_loanio_bridge with a response scoreboard; also covers LOANIO_DEBOUNCE_EN.
module tb_hps_loanio_bridge;
    import hps_loanio_pkg::*;

    localparam int NUM_CH      = 67;
    localparam int SYNC_STAGES = 2;
`ifdef LOANIO_DEBOUNCE_EN
    localparam int DEB_DIV = 4;
`else
    localparam int DEB_DIV = 1000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       gp_out;
    logic [31:0]       gp_in;
    logic [NUM_CH-1:0] loanio_in;
    logic [NUM_CH-1:0] loanio_out;
    logic [NUM_CH-1:0] loanio_oe;
    logic              edge_irq;

    hps_loanio_bridge #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_DIV     (DEB_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gp_out     (gp_out),
        .gp_in      (gp_in),
        .loanio_in  (loanio_in),
        .loanio_out (loanio_out),
        .loanio_oe  (loanio_oe),
        .edge_irq   (edge_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        bit          chk_rdata;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic tog;
    logic [NUM_CH-1:0] m_out, m_oe;
    int lat;

    localparam logic [NUM_CH-1:0] PAT = {3'b101, 64'hDEAD_BEEF_1234_5678};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [6:0] idx,
                        input logic [15:0] data, input logic exp_err, input logic [15:0] exp_rd,
                        input bit chk_rd, input bit flip_ch5, output int lat_o);
        exp_t e;
        e.err = exp_err;
        e.rdata = exp_rd;
        e.chk_rdata = chk_rd;
        sb.push_back(e);
        @(negedge clk);
        gp_out = {tog, op, idx, 5'b0, data};
        repeat (3) @(negedge clk);
        tog = ~tog;
        gp_out[31] = tog;
        lat_o = 0;
        if (flip_ch5) begin
            @(negedge clk);
            loanio_in[5] = ~loanio_in[5];
            lat_o = 1;
        end
        while (gp_in[31] !== tog && lat_o < 40) begin
            @(negedge clk);
            lat_o++;
        end
        check({tag, " ack"}, gp_in[31], tog);
        e = sb.pop_front();
        check({tag, " err"}, gp_in[30], e.err);
        if (e.chk_rdata) check({tag, " rdata"}, gp_in[15:0], e.rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tog = 1'b1;
        gp_out = 32'h8000_0000;
        loanio_in = PAT;
        reset = 1'b1;
        m_out = '0;
        m_oe = '0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset gp_in", gp_in, 32'h8000_0000);
        check("reset out", loanio_out, '0);
        check("reset oe", loanio_oe, '0);
        check("reset irq", edge_irq, 1'b0);

        send("wr_out_bank1", OP_WR_OUT_BANK, 7'd1, 16'hA5A5, 1'b0, 16'h0, 0, 0, lat);
        check("ack latency", lat, SYNC_STAGES + 2);
        m_out[31:16] = 16'hA5A5;
        check("out after bank1", loanio_out, m_out);

        send("wr_out_bit67", OP_WR_OUT_BIT, 7'd67, 16'h0001, 1'b1, 16'h0, 1, 0, lat);
        check("out unchanged on err", loanio_out, m_out);
        repeat (3) @(negedge clk);
        check("err holds", gp_in[31:30], {tog, 1'b1});

        send("wr_out_bit0", OP_WR_OUT_BIT, 7'd0, 16'h0001, 1'b0, 16'h0, 0, 0, lat);
        m_out[0] = 1'b1;
        check("out bit0", loanio_out, m_out);

        send("wr_oe_bit66", OP_WR_OE_BIT, 7'd66, 16'h0001, 1'b0, 16'h0, 0, 0, lat);
        m_oe[66] = 1'b1;
        check("oe bit66", loanio_oe, m_oe);

        send("wr_oe_bank4", OP_WR_OE_BANK, 7'd4, 16'hFFFF, 1'b0, 16'h0, 0, 0, lat);
        m_oe[66:64] = 3'b111;
        check("oe partial bank", loanio_oe, m_oe);

        send("rd_bit66", OP_RD_BIT, 7'd66, 16'h0, 1'b0,
             {12'b0, 1'b0, m_oe[66], m_out[66], PAT[66]}, 1, 0, lat);
        send("rd_bit16", OP_RD_BIT, 7'd16, 16'h0, 1'b0,
             {12'b0, 1'b0, m_oe[16], m_out[16], PAT[16]}, 1, 0, lat);
        send("rd_bank0", OP_RD_BANK, 7'd0, 16'h0, 1'b0, PAT[15:0], 1, 0, lat);
        send("rd_bank4", OP_RD_BANK, 7'd4, 16'h0, 1'b0, {13'b0, PAT[66:64]}, 1, 0, lat);
        send("rd_bank5", OP_RD_BANK, 7'd5, 16'h0, 1'b1, 16'h0, 1, 0, lat);
        send("wr_out_bank5", OP_WR_OUT_BANK, 7'd5, 16'hFFFF, 1'b1, 16'h0, 1, 0, lat);
        check("out unchanged bank err", loanio_out, m_out);
        send("nop", OP_NOP, 7'd0, 16'h0, 1'b0, 16'h0, 0, 0, lat);

        @(negedge clk);
        loanio_in[5] = ~loanio_in[5];
        repeat (20) @(negedge clk);
        loanio_in[5] = ~loanio_in[5];
        repeat (20) @(negedge clk);
        send("clr_read", OP_CLR_EDGE_BANK, 7'd0, 16'h0000, 1'b0, 16'h0020, 1, 0, lat);
        check("irq set", edge_irq, 1'b1);
        send("clr_ch5", OP_CLR_EDGE_BANK, 7'd0, 16'h0020, 1'b0, 16'h0020, 1, 0, lat);
        repeat (3) @(negedge clk);
        check("irq cleared", edge_irq, 1'b0);
        send("flags empty", OP_CLR_EDGE_BANK, 7'd0, 16'h0000, 1'b0, 16'h0000, 1, 0, lat);

`ifdef LOANIO_DEBOUNCE_EN
        loanio_in[5] = ~loanio_in[5];
        repeat (5) @(negedge clk);
        loanio_in[5] = ~loanio_in[5];
        repeat (20) @(negedge clk);
        send("glitch no edge", OP_CLR_EDGE_BANK, 7'd0, 16'h0000, 1'b0, 16'h0000, 1, 0, lat);
        loanio_in[5] = ~loanio_in[5];
        repeat (16) @(negedge clk);
        send("held edge", OP_CLR_EDGE_BANK, 7'd0, 16'h0000, 1'b0, 16'h0020, 1, 0, lat);
`else
        send("clr_vs_set", OP_CLR_EDGE_BANK, 7'd0, 16'h0020, 1'b0, 16'h0000, 1, 1, lat);
        repeat (3) @(negedge clk);
        send("set wins", OP_CLR_EDGE_BANK, 7'd0, 16'h0000, 1'b0, 16'h0020, 1, 0, lat);
        check("irq after set wins", edge_irq, 1'b1);
`endif

        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
